// File: rtl/vc_arbiter_4to1.sv
`default_nettype none
// ============================================================================
// Module   : vc_arbiter_4to1
// Purpose  : Round-robin, burst-limited drain of four VC FIFOs into one FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module vc_arbiter_4to1 #(
    parameter int DATA_WIDTH = 12,
    parameter int BURST      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  empty_0,
    input  logic                  empty_1,
    input  logic                  empty_2,
    input  logic                  empty_3,
    input  logic [DATA_WIDTH-1:0] data_in_0,
    input  logic [DATA_WIDTH-1:0] data_in_1,
    input  logic [DATA_WIDTH-1:0] data_in_2,
    input  logic [DATA_WIDTH-1:0] data_in_3,
    input  logic                  almost_full,
    output logic                  pop_0,
    output logic                  pop_1,
    output logic                  pop_2,
    output logic                  pop_3,
    output logic                  push,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            grant,
    output logic                  busy
);

    localparam logic [0:0] c_ST_IDLE    = 1'b0;
    localparam logic [0:0] c_ST_GRANT   = 1'b1;
    localparam logic [3:0] c_BURST_LAST = 4'(BURST - 1);

    logic [0:0]            r_state;
    logic [1:0]            r_grant;
    logic [1:0]            r_grant_d;
    logic [1:0]            r_rr_ptr;
    logic [3:0]            r_burst_cnt;
    logic                  r_push;

    logic [3:0]            w_empty;
    logic [DATA_WIDTH-1:0] w_data [4];
    logic                  w_empty_g;
    logic                  w_pop_any;
    logic [3:0]            w_pop;
    logic                  w_release;
    logic                  w_any;
    logic [1:0]            w_pick;
    logic [1:0]            w_idx;

    assign w_empty   = {empty_3, empty_2, empty_1, empty_0};
    assign w_data[0] = data_in_0;
    assign w_data[1] = data_in_1;
    assign w_data[2] = data_in_2;
    assign w_data[3] = data_in_3;

    assign w_empty_g = w_empty[r_grant];
    // Pops are held off while reset is high so no word is lost to a discarded grant.
    assign w_pop_any = (r_state == c_ST_GRANT) && !w_empty_g && !almost_full && !reset;
    assign w_pop     = w_pop_any ? (4'b0001 << r_grant) : 4'b0000;
    assign w_release = (r_state == c_ST_GRANT) &&
                       (w_empty_g || (w_pop_any && (r_burst_cnt == c_BURST_LAST)));
    assign w_any     = ~&w_empty;

    // Scan from rr_ptr upward; descending loop lets the nearest candidate win.
    always_comb begin
        w_pick = r_rr_ptr;
        w_idx  = r_rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_rr_ptr + 2'(k);
            if (!w_empty[w_idx]) begin
                w_pick = w_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_grant     <= 2'd0;
            r_grant_d   <= 2'd0;
            r_rr_ptr    <= 2'd0;
            r_burst_cnt <= 4'd0;
            r_push      <= 1'b0;
        end else begin
            r_push    <= w_pop_any;
            r_grant_d <= r_grant;
            if (r_state == c_ST_IDLE) begin
                if (w_any) begin
                    r_grant     <= w_pick;
                    r_burst_cnt <= 4'd0;
                    r_state     <= c_ST_GRANT;
                end
            end else begin
                if (w_release) begin
                    r_rr_ptr    <= r_grant + 2'd1;
                    r_burst_cnt <= 4'd0;
                    r_state     <= c_ST_IDLE;
                end else if (w_pop_any) begin
                    r_burst_cnt <= r_burst_cnt + 4'd1;
                end
            end
        end
    end

    assign pop_0    = w_pop[0];
    assign pop_1    = w_pop[1];
    assign pop_2    = w_pop[2];
    assign pop_3    = w_pop[3];
    assign push     = r_push;
    assign data_out = r_push ? w_data[r_grant_d] : '0;
    assign grant    = r_grant;
    assign busy     = (r_state == c_ST_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_vc_arbiter_4to1.sv
`default_nettype none
// ============================================================================
// Module   : tb_vc_arbiter_4to1
// Purpose  : Directed bench for vc_arbiter_4to1 (BURST=4 and BURST=1 builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vc_arbiter_4to1;

    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          almost_full;
    logic [3:0]    emp;
    logic [DW-1:0] din [4];
    logic          sel;

    logic          a_pop_0, a_pop_1, a_pop_2, a_pop_3, a_push, a_busy;
    logic [DW-1:0] a_data_out;
    logic [1:0]    a_grant;
    logic          b_pop_0, b_pop_1, b_pop_2, b_pop_3, b_push, b_busy;
    logic [DW-1:0] b_data_out;
    logic [1:0]    b_grant;

    always #5 clk = ~clk;

    vc_arbiter_4to1 #(.DATA_WIDTH(DW), .BURST(4)) dut (
        .clk(clk), .reset(reset),
        .empty_0(emp[0]), .empty_1(emp[1]), .empty_2(emp[2]), .empty_3(emp[3]),
        .data_in_0(din[0]), .data_in_1(din[1]), .data_in_2(din[2]), .data_in_3(din[3]),
        .almost_full(almost_full),
        .pop_0(a_pop_0), .pop_1(a_pop_1), .pop_2(a_pop_2), .pop_3(a_pop_3),
        .push(a_push), .data_out(a_data_out), .grant(a_grant), .busy(a_busy)
    );

    vc_arbiter_4to1 #(.DATA_WIDTH(DW), .BURST(1)) dut_b1 (
        .clk(clk), .reset(reset),
        .empty_0(emp[0]), .empty_1(emp[1]), .empty_2(emp[2]), .empty_3(emp[3]),
        .data_in_0(din[0]), .data_in_1(din[1]), .data_in_2(din[2]), .data_in_3(din[3]),
        .almost_full(almost_full),
        .pop_0(b_pop_0), .pop_1(b_pop_1), .pop_2(b_pop_2), .pop_3(b_pop_3),
        .push(b_push), .data_out(b_data_out), .grant(b_grant), .busy(b_busy)
    );

    // Source FIFO contents and the scheduler's view of who owns the output.
    logic [DW-1:0] fq [4][$];
    int            pcnt [4];
    int            plog [$];
    int            vectors = 0;
    int            miscompares = 0;

    bit            m_busy;
    int            m_owner, m_turn, m_taken;
    bit            m_push;
    logic [DW-1:0] m_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    task automatic sync_emp();
        for (int v = 0; v < 4; v++) emp[v] = (fq[v].size() == 0);
    endtask

    task automatic fill(input int v, input int n, input int base);
        for (int i = 0; i < n; i++) fq[v].push_back(DW'(base + i));
        sync_emp();
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_owner = 0; m_turn = 0; m_taken = 0; m_push = 1'b0; m_word = '0;
    endtask

    // One clock: check outputs against the model, advance the model and FIFOs.
    task automatic step();
        logic [3:0]    ep, ap;
        bit            n_busy, n_push, found;
        int            n_owner, n_turn, n_taken, burst;
        logic [DW-1:0] w;
        #2;
        burst = sel ? 1 : 4;
        ep = 4'b0000;
        if (!reset && m_busy && fq[m_owner].size() > 0 && !almost_full) ep[m_owner] = 1'b1;
        ap = sel ? {b_pop_3, b_pop_2, b_pop_1, b_pop_0} : {a_pop_3, a_pop_2, a_pop_1, a_pop_0};
        chk("pop", 32'(ap), 32'(ep));
        chk("push", 32'(sel ? b_push : a_push), 32'(m_push));
        chk("data_out", 32'(sel ? b_data_out : a_data_out), 32'(m_push ? m_word : '0));
        chk("grant", 32'(sel ? b_grant : a_grant), 32'(m_owner));
        chk("busy", 32'(sel ? b_busy : a_busy), 32'(m_busy));

        n_busy = m_busy; n_owner = m_owner; n_turn = m_turn; n_taken = m_taken;
        n_push = (ep != 4'b0000);
        if (reset) begin
            n_busy = 1'b0; n_owner = 0; n_turn = 0; n_taken = 0; n_push = 1'b0;
        end else if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (!found && fq[(m_turn + k) % 4].size() > 0) begin
                    found = 1'b1; n_owner = (m_turn + k) % 4; n_busy = 1'b1; n_taken = 0;
                end
            end
        end else if (fq[m_owner].size() == 0) begin
            n_busy = 1'b0; n_turn = (m_owner + 1) % 4; n_taken = 0;
        end else if (ep != 4'b0000) begin
            n_taken = m_taken + 1;
            if (n_taken == burst) begin
                n_busy = 1'b0; n_turn = (m_owner + 1) % 4; n_taken = 0;
            end
        end

        @(posedge clk);
        #1;
        m_busy = n_busy; m_owner = n_owner; m_turn = n_turn; m_taken = n_taken; m_push = n_push;
        for (int v = 0; v < 4; v++) begin
            if (ep[v]) begin
                w = fq[v].pop_front();
                din[v] = w;
                m_word = w;
                pcnt[v]++;
                plog.push_back(v);
            end
        end
        sync_emp();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b1, b2, b3, pb, n;
        sel = 1'b0; reset = 1'b1; almost_full = 1'b0;
        for (int v = 0; v < 4; v++) begin din[v] = '0; pcnt[v] = 0; end
        model_reset();
        for (int v = 0; v < 4; v++) fill(v, 10, v * 256 + 1);
        @(posedge clk); #1; @(negedge clk);

        // Reset held with every VC non-empty, then full round-robin draining.
        run(3);
        reset = 1'b0;
        step();
        chk("t1_no_pop_in_idle", pcnt[0], 0);
        step();
        chk("t1_first_pop_vc0", pcnt[0], 1);
        run(38);
        for (int v = 0; v < 4; v++) chk($sformatf("t2_pops_vc%0d_after_two_rounds", v), pcnt[v], 8);
        chk("t2_order_3", plog[3], 0);
        chk("t2_order_4", plog[4], 1);
        chk("t2_order_8", plog[8], 2);
        chk("t2_order_12", plog[12], 3);
        chk("t2_order_16", plog[16], 0);
        run(20);
        for (int v = 0; v < 4; v++) chk($sformatf("t2_drained_vc%0d", v), pcnt[v], 10);

        // Lone VC2, then refilled alone: scan from rr_ptr=3 wraps back to it.
        b2 = pcnt[2];
        fill(2, 2, 12'h800);
        run(6);
        chk("t3_two_pops_vc2", pcnt[2] - b2, 2);
        fill(2, 3, 12'h810);
        run(8);
        chk("t3_refill_pops_vc2", pcnt[2] - b2, 5);
        chk("t3_vc0_untouched", pcnt[0], 10);

        // Stall mid-burst on VC1.
        b1 = pcnt[1]; b2 = pcnt[2]; pb = plog.size();
        fill(1, 4, 12'h900);
        fill(2, 4, 12'hA00);
        n = 0;
        while (pcnt[1] - b1 < 2 && n < 8) begin step(); n++; end
        chk("t4_two_pops_reached", pcnt[1] - b1, 2);
        almost_full = 1'b1;
        run(5);
        chk("t4_stall_no_pop", pcnt[1] - b1, 2);
        chk("t4_grant_held", 32'(a_grant), 1);
        almost_full = 1'b0;
        run(12);
        chk("t4_vc1_total", pcnt[1] - b1, 4);
        chk("t4_vc2_total", pcnt[2] - b2, 4);
        chk("t4_rotation_to_vc2", plog[pb + 4], 2);

        // Reset in the cycle after a pop_3.
        b3 = pcnt[3];
        fill(3, 3, 12'hB00);
        fill(1, 2, 12'hC00);
        n = 0;
        while (pcnt[3] == b3 && n < 8) begin step(); n++; end
        chk("t5_pop3_reached", pcnt[3] - b3, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_push_suppressed", 32'(a_push), 0);
        chk("t5_idle_after_reset", 32'(a_busy), 0);
        pb = plog.size();
        run(10);
        chk("t5_lowest_vc_first", plog[pb], 1);
        chk("t5_vc3_total", pcnt[3] - b3, 3);

        // BURST=1 build: strict alternation 0,1,2,3.
        sel = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        model_reset();
        @(negedge clk);
        for (int v = 0; v < 4; v++) fill(v, 4, 12'hD00 + v * 16);
        run(2);
        reset = 1'b0;
        b1 = pcnt[0]; b2 = pcnt[1]; b3 = pcnt[2]; n = pcnt[3]; pb = plog.size();
        run(40);
        chk("t6_vc0_pops", pcnt[0] - b1, 4);
        chk("t6_vc1_pops", pcnt[1] - b2, 4);
        chk("t6_vc2_pops", pcnt[2] - b3, 4);
        chk("t6_vc3_pops", pcnt[3] - n, 4);
        for (int i = 0; i < 5; i++) chk($sformatf("t6_order_%0d", i), plog[pb + i], i % 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
